// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// Winner's operands are steered to the ALU and the result lands in a single tagged response register.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [15:0]      busy_cycles
);

    logic             r_last_grant;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic [15:0]      r_busy_cycles;

    logic w_free;
    logic w_grant0;
    logic w_grant1;
    logic w_any_grant;

    // On a tie the requester that did not win last time gets the slot.
    assign w_free      = !r_rsp_valid || rsp_ready;
    assign w_grant0    = !rst && w_free && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1    = !rst && w_free && req1_valid && (!req0_valid || !r_last_grant);
    assign w_any_grant = w_grant0 || w_grant1;

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;

    always_comb begin
        alu_op = 3'b000;
        alu_a  = '0;
        alu_b  = '0;
        if (w_grant0) begin
            alu_op = req0_op;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end else if (w_grant1) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_data    <= '0;
            r_busy_cycles <= 16'd0;
            r_last_grant  <= 1'b1;
        end else if (w_any_grant) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= w_grant1;
            r_rsp_data    <= alu_result;
            r_last_grant  <= w_grant1;
            if (r_busy_cycles != 16'hFFFF) begin
                r_busy_cycles <= r_busy_cycles + 16'd1;
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign busy_cycles = r_busy_cycles;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed bench for alu_share_arbiter
// A transaction-level model predicts the grant, ALU drive and response each cycle.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic [15:0]      busy_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the response slot should hold and who won last.
    logic             m_valid;
    logic             m_id;
    logic [WIDTH-1:0] m_data;
    int               m_busy;
    int               m_last;
    int               last_g;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy_cycles(busy_cycles)
    );

    function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b011:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check combinational grant/drive at negedge, then the registered response.
    task automatic cycle();
        int g;
        logic [2:0]       eo;
        logic [WIDTH-1:0] ea, eb;
        @(negedge clk);
        g = -1;
        if (!rst && (!m_valid || rsp_ready)) begin
            if (req0_valid && req1_valid) g = 1 - m_last;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        eo = 3'b000; ea = '0; eb = '0;
        if (g == 0) begin eo = req0_op; ea = req0_a; eb = req0_b; end
        if (g == 1) begin eo = req1_op; ea = req1_a; eb = req1_b; end
        check("req0_ready", req0_ready, g == 0);
        check("req1_ready", req1_ready, g == 1);
        check("alu_op", alu_op, eo);
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_id = 0; m_data = '0; m_busy = 0; m_last = 1;
        end else if (g >= 0) begin
            m_valid = 1;
            m_id    = (g == 1);
            m_data  = alu_ref(eo, ea, eb);
            m_last  = g;
            m_busy  = (m_busy < 65535) ? m_busy + 1 : 65535;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        last_g = g;
        #1;
        check("rsp_valid", rsp_valid, m_valid);
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
        check("busy_cycles", busy_cycles, m_busy);
    endtask

    task automatic new_req0(input logic v);
        req0_valid = v;
        req0_op = 3'($urandom_range(0, 7));
        req0_a  = $urandom;
        req0_b  = $urandom;
    endtask

    task automatic new_req1(input logic v);
        req1_valid = v;
        req1_op = 3'($urandom_range(0, 7));
        req1_a  = $urandom;
        req1_b  = $urandom;
    endtask

    initial begin
        m_valid = 0; m_id = 0; m_data = '0; m_busy = 0; m_last = 1; last_g = -1;
        rst = 1; rsp_ready = 1;
        new_req0(0); new_req1(0);
        repeat (2) cycle();
        rst = 0;

        // Single request: 5 + 7
        req0_valid = 1; req0_op = 3'b011; req0_a = 5; req0_b = 7;
        cycle();
        check("single_rsp_data", rsp_data, 12);
        check("single_busy", busy_cycles, 1);
        req0_valid = 0;
        cycle();

        // Reset, then continuous tie: alternation starts with requester 0
        rst = 1; cycle(); rst = 0;
        req0_valid = 1; req0_op = 3'b011; req0_a = 1; req0_b = 1;
        req1_valid = 1; req1_op = 3'b110; req1_a = 9; req1_b = 4;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("tie_id", rsp_id, i % 2);
            check("tie_data", rsp_data, (i % 2) ? 5 : 2);
        end
        // rsp holds (1,5); backpressure for 3 cycles with only req0 valid
        req1_valid = 0; rsp_ready = 0;
        repeat (3) begin
            cycle();
            check("bp_data", rsp_data, 5);
        end
        rsp_ready = 1;
        cycle();
        check("bp_release_id", rsp_id, 0);
        check("bp_release_data", rsp_data, 2);

        // Drain without refill; next tie goes to requester 1
        req0_valid = 0;
        cycle();
        check("drain_valid", rsp_valid, 0);
        req0_valid = 1; req1_valid = 1;
        cycle();
        check("post_drain_tie", rsp_id, 1);

        // Reset mid-operation with both valid
        rsp_ready = 0;
        cycle();
        rst = 1; cycle(); rst = 0;
        rsp_ready = 1;
        cycle();
        check("post_reset_tie", rsp_id, 0);

        // Randomized traffic, requests held until accepted
        new_req0(1'($urandom)); new_req1(1'($urandom));
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
            rst = 0;
            if (last_g == 0 || !req0_valid) new_req0(1'($urandom));
            if (last_g == 1 || !req1_valid) new_req1(1'($urandom));
        end

        // Saturation: 65,536 consecutive grants after a reset
        rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        cycle(); rst = 0;
        req0_valid = 1; req0_op = 3'b011; req0_a = 3; req0_b = 4;
        repeat (65536) @(posedge clk);
        m_valid = 1; m_id = 0; m_data = 7; m_last = 0; m_busy = 65535;
        #1;
        check("sat_busy", busy_cycles, 16'hFFFF);
        repeat (2) cycle();
        check("sat_hold", busy_cycles, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
